// File: rtl/ahbl_pkg.sv
// ----------------------------------------------------------------------------
// ahbl_pkg
// Shared AHB-Lite definitions used by the splitter and its default slave.
//   - HTRANS encodings (IDLE/BUSY/NONSEQ/SEQ)
//   - HRESP codes (OKAY/ERROR)
//   - default-slave FSM state constants
//   - ahbl_rsp_t: one data-phase response (ready, resp, rdata) so the
//     splitter can mux whole responses instead of three separate buses
// No ports (package).
// ----------------------------------------------------------------------------
package ahbl_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  // Default-slave FSM states.
  localparam logic [1:0] DS_IDLE = 2'd0;
  localparam logic [1:0] DS_ERR1 = 2'd1;
  localparam logic [1:0] DS_ERR2 = 2'd2;

  typedef struct packed {
    logic        ready;
    logic        resp;
    logic [31:0] rdata;
  } ahbl_rsp_t;

  // Response of an idle bus: zero-wait OKAY with zero read data.
  localparam ahbl_rsp_t RSP_IDLE = '{ready: 1'b1, resp: HRESP_OKAY, rdata: 32'h0};

  // NONSEQ and SEQ carry a real transfer; IDLE and BUSY do not.
  function automatic logic is_active(input logic [1:0] htrans);
    return (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
  endfunction

endpackage

// File: rtl/ahbl_default_slave.sv
// ----------------------------------------------------------------------------
// ahbl_default_slave
// Answers transfers that hit no mapped slave with the two-cycle AHB ERROR
// response: first cycle HREADYOUT=0/HRESP=1, second cycle HREADYOUT=1/HRESP=1.
// HRDATA is always zero.
//
// Ports
//   clk             in   bus clock, rising edge
//   rst_n           in   asynchronous active-low reset
//   accept_unmapped in   an unmapped NONSEQ/SEQ is accepted this cycle
//                        (HREADY already folded in by the caller)
//   rsp             out  data-phase response while this slave owns the bus
//   state_dbg       out  current FSM state (DS_IDLE/DS_ERR1/DS_ERR2)
// ----------------------------------------------------------------------------
module ahbl_default_slave
  import ahbl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       accept_unmapped,
  output ahbl_rsp_t  rsp,
  output logic [1:0] state_dbg
);

  logic [1:0] state;
  logic [1:0] state_nxt;

  always_comb begin
    state_nxt = state;
    case (state)
      DS_IDLE: if (accept_unmapped) state_nxt = DS_ERR1;
      DS_ERR1: state_nxt = DS_ERR2;
      // The ERR2 cycle is ready, so a new unmapped transfer may be
      // accepted in it and restarts the error response without a gap.
      DS_ERR2: state_nxt = accept_unmapped ? DS_ERR1 : DS_IDLE;
      default: state_nxt = DS_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= DS_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    rsp = RSP_IDLE;
    case (state)
      DS_ERR1: rsp = '{ready: 1'b0, resp: HRESP_ERROR, rdata: 32'h0};
      DS_ERR2: rsp = '{ready: 1'b1, resp: HRESP_ERROR, rdata: 32'h0};
      default: rsp = RSP_IDLE;
    endcase
  end

  assign state_dbg = state;

endmodule

// File: rtl/ahbl_splitter_n.sv
// ----------------------------------------------------------------------------
// ahbl_splitter_n
// AHB-Lite 1-to-NSLV splitter. Decodes HADDR[DEC_HI:DEC_LO] against a table of
// per-slave base values, drives one-hot slave selects, and muxes the response
// of whichever slave owns the current data phase back to the master.
//
// Build option: define AHBL_SPLITTER_N_ERR_EN to answer unmapped NONSEQ/SEQ
// transfers with a two-cycle ERROR (ahbl_default_slave). Without it, unmapped
// transfers get a single-cycle OKAY with zero read data.
//
// Parameters
//   NSLV    number of slaves (2..16)
//   DEC_HI  MSB of the decoded address field
//   DEC_LO  LSB of the decoded address field
//   BASES   packed NSLV*DECW table; slave i matches BASES[i*DECW +: DECW]
//
// Ports
//   HCLK, HRESETn        clock, asynchronous active-low reset
//   HSEL                 splitter selected by the upstream decoder
//   HADDR, HTRANS        address-phase address and transfer type
//   HREADY               bus-wide ready
//   HREADYOUT/HRESP/HRDATA  response of the current data-phase owner
//   S_HSEL               per-slave select (bit i = slave i)
//   S_HRDATA/S_HREADYOUT/S_HRESP  per-slave response inputs
//   dbg_err_state        default-slave FSM state (DS_IDLE when built without it)
//
// Handshake: an address phase is accepted on a rising HCLK edge where
// HREADY=1; that edge also ends the previous data phase, so the data-phase
// owner is reloaded from the address-phase decode exactly on those edges and
// held while HREADY=0 (wait states).
// ----------------------------------------------------------------------------
module ahbl_splitter_n
  import ahbl_pkg::*;
#(
  parameter int NSLV   = 5,
  parameter int DEC_HI = 31,
  parameter int DEC_LO = 28,
  parameter logic [NSLV*(DEC_HI-DEC_LO+1)-1:0] BASES = {4'h6, 4'h8, 4'h4, 4'h2, 4'h0}
) (
  input  logic               HCLK,
  input  logic               HRESETn,
  input  logic               HSEL,
  input  logic [31:0]        HADDR,
  input  logic [1:0]         HTRANS,
  input  logic               HREADY,
  output logic               HREADYOUT,
  output logic [31:0]        HRDATA,
  output logic               HRESP,
  output logic [NSLV-1:0]    S_HSEL,
  input  logic [NSLV*32-1:0] S_HRDATA,
  input  logic [NSLV-1:0]    S_HREADYOUT,
  input  logic [NSLV-1:0]    S_HRESP,
  output logic [1:0]         dbg_err_state
);

  localparam int DECW     = DEC_HI - DEC_LO + 1;
  // Owner one-hot layout: bits [NSLV-1:0] slaves, then default, then none.
  localparam int OWN_DEF  = NSLV;
  localparam int OWN_NONE = NSLV + 1;
  localparam int OWNW     = NSLV + 2;
  localparam logic [OWNW-1:0] OWNER_NONE = {1'b1, {(NSLV+1){1'b0}}};

  logic [DECW-1:0] dec_field;
  logic [NSLV-1:0] match;
  logic            any_match;
  logic            taken;
  logic            unmapped_req;
  logic [OWNW-1:0] owner;
  logic [OWNW-1:0] owner_nxt;
  ahbl_rsp_t       ds_rsp;
  ahbl_rsp_t       rsp;
  logic            unused_bits;

  assign dec_field = HADDR[DEC_HI:DEC_LO];

  always_comb begin
    for (int i = 0; i < NSLV; i++) begin
      match[i] = (dec_field == BASES[i*DECW +: DECW]);
    end
  end

  assign any_match = |match;

  // Overlapping bases resolve to the lowest index so S_HSEL stays one-hot.
  always_comb begin
    S_HSEL = '0;
    taken  = 1'b0;
    for (int i = 0; i < NSLV; i++) begin
      if (HSEL && match[i] && !taken) begin
        S_HSEL[i] = 1'b1;
        taken     = 1'b1;
      end
    end
  end

  // Only real transfers reach the default slave; unmapped IDLE/BUSY leave
  // the owner at "none" and so see a zero-wait OKAY.
  assign unmapped_req = HSEL && is_active(HTRANS) && !any_match;

  always_comb begin
    owner_nxt = '0;
    if (|S_HSEL) begin
      owner_nxt[NSLV-1:0] = S_HSEL;
    end else if (unmapped_req) begin
      owner_nxt[OWN_DEF] = 1'b1;
    end else begin
      owner_nxt[OWN_NONE] = 1'b1;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      owner <= OWNER_NONE;
    end else if (HREADY) begin
      owner <= owner_nxt;
    end
  end

`ifdef AHBL_SPLITTER_N_ERR_EN
  ahbl_default_slave u_default_slave (
    .clk             (HCLK),
    .rst_n           (HRESETn),
    .accept_unmapped (HREADY && unmapped_req),
    .rsp             (ds_rsp),
    .state_dbg       (dbg_err_state)
  );
`else
  // No error FSM: an unmapped transfer is completed as a plain OKAY.
  assign ds_rsp        = RSP_IDLE;
  assign dbg_err_state = DS_IDLE;
`endif

  // Owner is one-hot, so at most one branch below fires; "none" keeps the
  // idle response.
  always_comb begin
    rsp = RSP_IDLE;
    for (int i = 0; i < NSLV; i++) begin
      if (owner[i]) begin
        rsp = '{ready: S_HREADYOUT[i], resp: S_HRESP[i], rdata: S_HRDATA[i*32 +: 32]};
      end
    end
    if (owner[OWN_DEF]) begin
      rsp = ds_rsp;
    end
  end

  assign HREADYOUT = rsp.ready;
  assign HRESP     = rsp.resp;
  assign HRDATA    = rsp.rdata;

  // Address bits outside the decoded field and the "none" owner bit carry
  // no logic of their own.
  assign unused_bits = ^{HADDR, owner[OWN_NONE]};

endmodule

// File: doc/ahbl_splitter_n.md
AHBL_SPLITTER_N -- requirements
Module: ahbl_splitter_n

Interface
REQ-001 The block SHALL have parameter NSLV, default 5, meaning number of attached slaves (legal 2..16).
REQ-002 The block SHALL have parameter DEC_HI, default 31, meaning MSB of the decoded HADDR field.
REQ-003 The block SHALL have parameter DEC_LO, default 28, meaning LSB of the decoded HADDR field; DECW = DEC_HI-DEC_LO+1.
REQ-004 The block SHALL have parameter BASES, default {4'h6,4'h8,4'h4,4'h2,4'h0}, meaning a packed NSLV*DECW vector; slave i's match value is BASES[i*DECW +: DECW].
REQ-005 HCLK  in  1  bus clock; all state on rising edge.
REQ-006 HRESETn  in  1  reset, asynchronous assert, active-low.
REQ-007 HSEL  in  1  splitter selected by the upstream decoder; tie 1 at top level.
REQ-008 HADDR  in  32  address-phase address.
REQ-009 HTRANS  in  2  transfer type (IDLE/BUSY/NONSEQ/SEQ).
REQ-010 HREADY  in  1  bus-wide ready; address phase accepted when high.
REQ-011 HREADYOUT  out  1  ready of the data phase currently owned by this splitter.
REQ-012 HRDATA  out  32  read data muxed from the data-phase owner.
REQ-013 HRESP  out  1  response muxed from the data-phase owner (1 = ERROR).
REQ-014 S_HSEL  out  NSLV  per-slave select, bit i = slave i.
REQ-015 S_HRDATA  in  NSLV*32  slave read data, slave i at [i*32 +: 32].
REQ-016 S_HREADYOUT  in  NSLV  per-slave ready.
REQ-017 S_HRESP  in  NSLV  per-slave response.

Function
REQ-018 S_HSEL[i] SHALL be combinational: HSEL & (HADDR[DEC_HI:DEC_LO] == base i), independent of HTRANS; on overlapping bases, only the lowest matching index SHALL be asserted.
REQ-019 A registered one-hot data-phase owner (NSLV slaves + default slave + none) SHALL update only on cycles with HREADY=1; the owner is slave i if S_HSEL[i], default if HSEL & HTRANS[1] & no match, otherwise none.
REQ-020 When the owner is slave i, HRDATA/HREADYOUT/HRESP SHALL equal S_HRDATA[i]/S_HREADYOUT[i]/S_HRESP[i] with zero added latency.
REQ-021 When the owner is none (IDLE/BUSY, HSEL=0, or after reset), outputs SHALL be HREADYOUT=1, HRESP=0, HRDATA=0.
REQ-022 The default slave SHALL be an FSM with states IDLE, ERR1, ERR2: IDLE->ERR1 on an accepted unmapped NONSEQ/SEQ; ERR1->ERR2 unconditionally; ERR2->ERR1 if another unmapped transfer is accepted that cycle, else IDLE.
REQ-023 Default-slave outputs: IDLE: HREADYOUT=1, HRESP=0; ERR1: HREADYOUT=0, HRESP=1; ERR2: HREADYOUT=1, HRESP=1; HRDATA=0 in all states.
REQ-024 Back-to-back transfers to different slaves SHALL hand over the data mux on the HREADY=1 edge, with no bubble.
REQ-025 Unmapped IDLE or BUSY transfers SHALL produce a zero-wait OKAY response and never an ERROR.

Reset
REQ-026 On HRESETn low, the owner SHALL clear to none and the FSM to IDLE immediately, giving HREADYOUT=1, HRESP=0, HRDATA=0, including mid-wait-state or mid-ERROR.

Configuration
REQ-027 With AHBL_SPLITTER_N_ERR_EN defined, unmapped transfers SHALL use the two-cycle ERROR FSM of REQ-022/023.
REQ-028 Without AHBL_SPLITTER_N_ERR_EN, unmapped transfers SHALL get a single-cycle OKAY with HRDATA=0, the FSM SHALL be absent, and HRESP SHALL be constant 0 unless a slave drives ERROR.

Structure
REQ-029 HTRANS encodings (IDLE/BUSY/NONSEQ/SEQ) and HRESP codes (OKAY/ERROR) SHALL live in the shared package ahbl_pkg.
REQ-030 The error FSM SHALL be a sub-module named ahbl_default_slave.

Verification
REQ-031 Read 0x2000_0010 with S1 at 2 wait states returning 0xDEADBEEF -> S_HSEL=5'b00010; HREADYOUT low for 2 cycles, then high with HRDATA=0xDEADBEEF and HRESP=0.
REQ-032 ERR_EN defined, NONSEQ read 0xF000_0000 -> cycle 1: HREADYOUT=0, HRESP=1; cycle 2: HREADYOUT=1, HRESP=1. ERR_EN undefined -> one cycle with HREADYOUT=1, HRESP=0, HRDATA=0.
REQ-033 Pipelined NONSEQ 0x0000_0100 (S0 data 0x11111111) then 0x8000_0000 (S3 data 0x33333333) -> consecutive data phases return 0x11111111 then 0x33333333, with no idle cycle.
REQ-034 IDLE transfer to 0xF000_0000 -> HREADYOUT=1, HRESP=0, and the FSM stays in IDLE.
REQ-035 HSEL=0 with HADDR=0x2000_0000 -> S_HSEL=0 and the following data phase is OKAY/ready/0.
REQ-036 Assert HRESETn low during S1's wait state or ERR1 -> HREADYOUT=1, HRESP=0, HRDATA=0 before the next HCLK edge.
